// File: rtl/bus_slave_mux_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_mux_reg_pkg
// Description : Shared bus constants, FSM state encodings and a small
//               index-width helper for the registered slave-response mux.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_slave_mux_reg_pkg;

    // Active-low bus signalling levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Default read-data width
    localparam int DEF_DATA_WIDTH = 32;

    // Transaction FSM encoding (binary, explicit width)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of a slave index; a single slave still needs a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bus_slave_mux_reg_pkg
`default_nettype wire

// File: rtl/bus_slave_mux_reg_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : bus_prio_enc
// Description : Combinational priority encoder over active-low chip selects.
//               Returns the index of the lowest active select and a hit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_prio_enc
    import bus_slave_mux_reg_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [NUM_SLAVES-1:0] cs_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  hit_o
);

    // Scan from the top down so the lowest active index is the last one written
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (cs_i[i] == ENABLE_) begin
                idx_o = IDX_W'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule : bus_prio_enc
`default_nettype wire

// File: rtl/bus_slave_mux_reg.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_mux_reg
// Description : Registered slave-response mux. Latches the decoded slave at
//               request start, returns a registered ready/read-data pulse and
//               raises a bus error on decode miss or slave timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_slave_mux_reg
    import bus_slave_mux_reg_pkg::*;
#(
    parameter int NUM_SLAVES     = 8,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_,
    input  logic [NUM_SLAVES-1:0]            cs_,
    input  logic [NUM_SLAVES-1:0]            s_ready_,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rd_data,
    output logic                             out_ready_,
    output logic [DATA_WIDTH-1:0]            out_rd_data,
    output logic                             out_err_,
    output logic                             busy
);

    localparam int IDX_W = idx_width(NUM_SLAVES);

    // Counter value on which the last permitted WAIT cycle ends in a timeout
    localparam logic [CNT_WIDTH-1:0] c_TO_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       sel_q,   sel_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                   ready_q, ready_d;
    logic                   err_q,   err_d;
    logic [DATA_WIDTH-1:0]  data_q,  data_d;

    logic [IDX_W-1:0]       w_idx;
    logic                   w_hit;
    logic                   w_slv_ready;
    logic [DATA_WIDTH-1:0]  w_slv_data;
    logic                   w_timeout;

    bus_prio_enc #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_prio_enc (
        .cs_i  (cs_),
        .idx_o (w_idx),
        .hit_o (w_hit)
    );

    // Only the latched slave is observed; cs_ is ignored once WAIT is entered
    assign w_slv_ready = s_ready_[sel_q];
    assign w_slv_data  = s_rd_data[int'(sel_q) * DATA_WIDTH +: DATA_WIDTH];
    assign w_timeout   = c_TO_EN && (cnt_q == c_TO_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; master abort outranks ready, ready outranks timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ == ENABLE_) begin
                    state_d = w_hit ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (req_ == DISABLE_) begin
                    state_d = ST_IDLE;
                end else if ((w_slv_ready == ENABLE_) || w_timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for selection, counter and the registered response
    always_comb begin
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ == ENABLE_) begin
                    if (w_hit) begin
                        sel_d = w_idx;
                        cnt_d = '0;
                    end else begin
                        ready_d = ENABLE_;
                        err_d   = ENABLE_;
                        data_d  = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (req_ == DISABLE_) begin
                    cnt_d = '0;
                end else if (w_slv_ready == ENABLE_) begin
                    ready_d = ENABLE_;
                    err_d   = DISABLE_;
                    data_d  = w_slv_data;
                end else if (w_timeout) begin
                    ready_d = ENABLE_;
                    err_d   = ENABLE_;
                    data_d  = '0;
                end else if (!(&cnt_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                ready_d = DISABLE_;
                err_d   = DISABLE_;
                data_d  = '0;
            end
            default: begin
                ready_d = DISABLE_;
                err_d   = DISABLE_;
                data_d  = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= '0;
            cnt_q   <= '0;
            ready_q <= DISABLE_;
            err_q   <= DISABLE_;
            data_q  <= '0;
        end else begin
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign out_ready_  = ready_q;
    assign out_err_    = err_q;
    assign out_rd_data = data_q;
    assign busy        = (state_q != ST_IDLE);

endmodule : bus_slave_mux_reg
`default_nettype wire

// File: tb/tb_bus_slave_mux_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_slave_mux_reg
// Description : Self-checking bench for bus_slave_mux_reg: vector table of
//               single transactions plus abort, reset, back-to-back and
//               timeout-disabled sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_slave_mux_reg;

    localparam int NS = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_;
    logic [NS-1:0]   cs_;
    logic [NS-1:0]   s_ready_;
    logic [NS*DW-1:0] s_rd_data;

    logic            out_ready_, out_err_, busy;
    logic [DW-1:0]   out_rd_data;
    logic            nt_ready_, nt_err_, nt_busy;
    logic [DW-1:0]   nt_rd_data;

    bus_slave_mux_reg #(
        .NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .req_(req_), .cs_(cs_), .s_ready_(s_ready_),
        .s_rd_data(s_rd_data), .out_ready_(out_ready_), .out_rd_data(out_rd_data),
        .out_err_(out_err_), .busy(busy)
    );

    bus_slave_mux_reg #(
        .NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0), .CNT_WIDTH(8)
    ) dut_nt (
        .clk(clk), .reset(reset), .req_(req_), .cs_(cs_), .s_ready_(s_ready_),
        .s_rd_data(s_rd_data), .out_ready_(nt_ready_), .out_rd_data(nt_rd_data),
        .out_err_(nt_err_), .busy(nt_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction: ready mask is FF before edge 1, 'early' for edges 1..k-1,
    // 'late' from edge k on. exp_lat is the edge index after which out_ready_ is low.
    typedef struct {
        logic [7:0]  cs;
        logic [7:0]  early;
        logic [7:0]  late;
        int          k;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int id);
        int lat;
        lat = -1;
        req_     = 1'b0;
        cs_      = v.cs;
        s_ready_ = 8'hFF;
        for (int n = 0; n < 20; n++) begin
            if (n >= 1) s_ready_ = (n >= v.k) ? v.late : v.early;
            @(posedge clk);
            @(negedge clk);
            if (n == 0) chk($sformatf("v%0d busy", id), 64'(busy), 64'd1);
            if (out_ready_ === 1'b0) begin
                lat = n;
                break;
            end
        end
        chk($sformatf("v%0d latency", id), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d data", id), 64'(out_rd_data), 64'(v.exp_data));
        chk($sformatf("v%0d err", id), 64'(out_err_), 64'(v.exp_err));
        req_     = 1'b1;
        cs_      = 8'hFF;
        s_ready_ = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d pulse end", id), {out_ready_, out_err_, busy, out_rd_data},
            {1'b1, 1'b1, 1'b0, 32'h0});
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req_     = 1'b1;
        cs_      = 8'hFF;
        s_ready_ = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] seq;
        logic       flag;

        for (int i = 0; i < NS; i++) s_rd_data[i*DW +: DW] = 32'hCAFE0000 + 32'(i);

        //          cs     early  late   k  lat data          err
        vecs[0] = '{8'hFB, 8'hFF, 8'hFB, 3, 3, 32'hCAFE0002, 1'b1}; // normal read
        vecs[1] = '{8'hF5, 8'hF7, 8'hF5, 3, 3, 32'hCAFE0001, 1'b1}; // priority, s3 ignored
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 1, 0, 32'h0,        1'b0}; // decode miss
        vecs[3] = '{8'hDF, 8'hFF, 8'hFF, 1, 4, 32'h0,        1'b0}; // timeout
        vecs[4] = '{8'hDF, 8'hFF, 8'hDF, 4, 4, 32'hCAFE0005, 1'b1}; // ready beats timeout
        vecs[5] = '{8'h7F, 8'hFF, 8'h7F, 1, 1, 32'hCAFE0007, 1'b1}; // minimum latency
        vecs[6] = '{8'h00, 8'hFF, 8'hFE, 2, 2, 32'hCAFE0000, 1'b1}; // all selected -> slave 0
        vecs[7] = '{8'hEF, 8'hFF, 8'hEF, 3, 3, 32'hCAFE0004, 1'b1}; // ready just before timeout

        do_reset();
        #1;
        chk("reset outputs", {out_ready_, out_err_, busy, out_rd_data},
            {1'b1, 1'b1, 1'b0, 32'h0});
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Abort in WAIT, with ready arriving on the same edge: abort wins, no pulse
        req_ = 1'b0; cs_ = 8'hFB; s_ready_ = 8'hFF;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        req_ = 1'b1; s_ready_ = 8'hFB;
        @(posedge clk); @(negedge clk);
        chk("abort busy", 64'(busy), 64'd0);
        flag = 1'b0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (out_ready_ !== 1'b1) flag = 1'b1;
        end
        chk("abort no pulse", 64'(flag), 64'd0);
        s_ready_ = 8'hFF; cs_ = 8'hFF;

        // Reset during RESP clears the pulse at once
        req_ = 1'b0; cs_ = 8'hFB;
        @(posedge clk); @(negedge clk);
        s_ready_ = 8'hFB;
        @(posedge clk); @(negedge clk);
        chk("pre-reset pulse", {out_ready_, out_rd_data}, {1'b0, 32'hCAFE0002});
        reset = 1'b1;
        #1;
        chk("reset in RESP", {out_ready_, out_err_, busy, out_rd_data},
            {1'b1, 1'b1, 1'b0, 32'h0});
        @(negedge clk);
        req_ = 1'b1; s_ready_ = 8'hFF; cs_ = 8'hFF;
        reset = 1'b0;

        // Reset mid-WAIT: immediate idle, and the lost transaction never responds
        req_ = 1'b0; cs_ = 8'hDF;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("wait busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("reset in WAIT", {out_ready_, busy}, {1'b1, 1'b0});
        @(negedge clk);
        req_ = 1'b1; s_ready_ = 8'hDF;
        reset = 1'b0;
        flag = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (out_ready_ !== 1'b1 || busy !== 1'b0) flag = 1'b1;
        end
        chk("no response after reset", 64'(flag), 64'd0);
        s_ready_ = 8'hFF; cs_ = 8'hFF;

        // Back-to-back: req_ held low, slave 2 always ready
        req_ = 1'b0; cs_ = 8'hFB; s_ready_ = 8'hFB;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); @(negedge clk);
            seq[n] = out_ready_;
        end
        chk("back-to-back ready seq", 64'(seq), 64'(6'b101101));
        req_ = 1'b1; s_ready_ = 8'hFF; cs_ = 8'hFF;
        @(posedge clk); @(negedge clk);

        // Timeout disabled: wait 1000 cycles, then a late ready still completes normally
        do_reset();
        req_ = 1'b0; cs_ = 8'hDF; s_ready_ = 8'hFF;
        flag = 1'b0;
        repeat (1000) begin
            @(posedge clk); @(negedge clk);
            if (nt_ready_ !== 1'b1 || nt_busy !== 1'b1) flag = 1'b1;
        end
        chk("no timeout when disabled", 64'(flag), 64'd0);
        s_ready_ = 8'hDF;
        @(posedge clk); @(negedge clk);
        chk("late ready response", {nt_ready_, nt_err_, nt_rd_data},
            {1'b0, 1'b1, 32'hCAFE0005});
        req_ = 1'b1; s_ready_ = 8'hFF; cs_ = 8'hFF;
        @(posedge clk); @(negedge clk);
        chk("late ready pulse end", {nt_ready_, nt_busy}, {1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_slave_mux_reg
`default_nettype wire
